gpio_axil_responder: RTL and testbench

AXI4-Lite responder for the GPIO window (base 0x0010_0000, length 0x10000) of the SoC crossbar. It terminates the crossbar's GPIO slave port and exposes a small register file: output data, output enable, synchronized input, and a toggle port. It drives the GPIO pins directly. Reads and writes are handled on independent channels, with one outstanding transaction per direction.

---
 rtl/gpio_axil_responder.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_gpio_axil_responder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_axil_responder.sv
// gpio_axil_responder
// AXI4-Lite slave terminating the crossbar's GPIO window. It holds the OUT, OE
// and synchronized-IN registers and accepts a write-only TOGGLE port. The read
// and write channels are independent, and each allows one transaction in flight.
//
// Write FSM
//   state  | meaning
//   W_IDLE | collecting AW and W (either order); commits once both are held
//   W_RESP | B response presented, waiting for b_ready_i
//
// Read FSM
//   state  | meaning
//   R_IDLE | ar_ready_o high, waiting for an AR handshake
//   R_RESP | R data/response presented, waiting for r_ready_i

module gpio_axil_responder #(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    NUM_GPIO   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 64'h0010_0000,
  parameter logic [ADDR_WIDTH-1:0] WINDOW_LEN = 64'h0001_0000
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [ADDR_WIDTH-1:0]   aw_addr_i,
  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  input  logic [DATA_WIDTH-1:0]   w_data_i,
  input  logic [DATA_WIDTH/8-1:0] w_strb_i,
  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  output logic [1:0]              b_resp_o,
  output logic                    b_valid_o,
  input  logic                    b_ready_i,
  input  logic [ADDR_WIDTH-1:0]   ar_addr_i,
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  output logic [DATA_WIDTH-1:0]   r_data_o,
  output logic [1:0]              r_resp_o,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic [NUM_GPIO-1:0]     gpio_o,
  output logic [NUM_GPIO-1:0]     gpio_oe_o,
  input  logic [NUM_GPIO-1:0]     gpio_i
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] REG_OUT    = 2'd0;
  localparam logic [1:0] REG_OE     = 2'd1;
  localparam logic [1:0] REG_IN     = 2'd2;
  localparam logic [1:0] REG_TOGGLE = 2'd3;

  // Offsets below this hit one of the four defined registers.
  localparam logic [ADDR_WIDTH-1:0] REG_SPAN = ADDR_WIDTH'(32);

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;

  // write channel state
  w_state_e                w_state_q, w_state_d;
  logic                    aw_have_q, aw_have_d;
  logic                    w_have_q,  w_have_d;
  logic [ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_d;
  logic [NUM_GPIO-1:0]     w_data_q,  w_data_d;
  logic [STRB_WIDTH-1:0]   w_strb_q,  w_strb_d;
  logic [1:0]              b_resp_q,  b_resp_d;

  // register file
  logic [NUM_GPIO-1:0]     out_q, out_d;
  logic [NUM_GPIO-1:0]     oe_q,  oe_d;

  // input synchronizer
  logic [NUM_GPIO-1:0]     sync1_q, sync1_d;
  logic [NUM_GPIO-1:0]     sync2_q, sync2_d;

  // read channel state
  r_state_e                r_state_q, r_state_d;
  logic [DATA_WIDTH-1:0]   r_data_q,  r_data_d;
  logic [1:0]              r_resp_q,  r_resp_d;

  // decode results
  logic [ADDR_WIDTH-1:0]   wr_offset, rd_offset;
  logic [1:0]              wr_sel,    rd_sel;
  logic [1:0]              wr_resp,   rd_resp;

  // strobe-qualified write data
  logic [DATA_WIDTH-1:0]   wr_bytes;
  logic [NUM_GPIO-1:0]     wr_mask;
  logic [NUM_GPIO-1:0]     wr_bits;

  logic [DATA_WIDTH-1:0]   rd_word;

  // Data and strobe bits above NUM_GPIO have no register behind them.
  logic                    unused_bits;
  assign unused_bits = ^{w_data_i, wr_bytes};

  // Classify the held write address and the live read address within the window.
  always_comb begin
    wr_offset = aw_addr_q - BASE_ADDR;
    rd_offset = ar_addr_i - BASE_ADDR;
    wr_sel    = wr_offset[4:3];
    rd_sel    = rd_offset[4:3];

    if ((aw_addr_q < BASE_ADDR) || (wr_offset >= WINDOW_LEN)) begin
      wr_resp = RESP_DECERR;
    end else if (wr_offset < REG_SPAN) begin
      wr_resp = RESP_OKAY;
    end else begin
      wr_resp = RESP_SLVERR;
    end

    if ((ar_addr_i < BASE_ADDR) || (rd_offset >= WINDOW_LEN)) begin
      rd_resp = RESP_DECERR;
    end else if (rd_offset < REG_SPAN) begin
      rd_resp = RESP_OKAY;
    end else begin
      rd_resp = RESP_SLVERR;
    end
  end

  // Expand byte strobes to a bit mask and qualify the held write data with it.
  always_comb begin
    wr_bytes = '0;
    for (int k = 0; k < STRB_WIDTH; k++) begin
      wr_bytes[8*k +: 8] = {8{w_strb_q[k]}};
    end
    wr_mask = wr_bytes[NUM_GPIO-1:0];
    wr_bits = w_data_q & wr_mask;
  end

  // Write FSM: capture AW and W independently, commit once both are held, then respond.
  always_comb begin
    w_state_d  = w_state_q;
    aw_have_d  = aw_have_q;
    w_have_d   = w_have_q;
    aw_addr_d  = aw_addr_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    b_resp_d   = b_resp_q;
    out_d      = out_q;
    oe_d       = oe_q;
    aw_ready_o = 1'b0;
    w_ready_o  = 1'b0;

    unique case (w_state_q)
      W_IDLE: begin
        aw_ready_o = !aw_have_q && !reset_i;
        w_ready_o  = !w_have_q && !reset_i;

        if (aw_valid_i && aw_ready_o) begin
          aw_have_d = 1'b1;
          aw_addr_d = aw_addr_i;
        end
        if (w_valid_i && w_ready_o) begin
          w_have_d = 1'b1;
          w_data_d = w_data_i[NUM_GPIO-1:0];
          w_strb_d = w_strb_i;
        end

        if (aw_have_q && w_have_q) begin
          b_resp_d = wr_resp;
          if (wr_resp == RESP_OKAY) begin
            unique case (wr_sel)
              REG_OUT:    out_d = (out_q & ~wr_mask) | wr_bits;
              REG_OE:     oe_d  = (oe_q & ~wr_mask) | wr_bits;
              REG_TOGGLE: out_d = out_q ^ wr_bits;
              default:    ;
            endcase
          end
          aw_have_d = 1'b0;
          w_have_d  = 1'b0;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (b_ready_i) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign b_valid_o = (w_state_q == W_RESP);
  assign b_resp_o  = b_resp_q;
  assign gpio_o    = out_q;
  assign gpio_oe_o = oe_q;

  // Write channel and register file state; reset drops any half-captured write.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      w_state_q <= W_IDLE;
      aw_have_q <= 1'b0;
      w_have_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_resp_q  <= RESP_OKAY;
      out_q     <= '0;
      oe_q      <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_have_q <= aw_have_d;
      w_have_q  <= w_have_d;
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      b_resp_q  <= b_resp_d;
      out_q     <= out_d;
      oe_q      <= oe_d;
    end
  end

  // Two-flop synchronizer for the asynchronous pin inputs.
  always_comb begin
    sync1_d = gpio_i;
    sync2_d = sync1_q;
  end

  // Synchronizer stages.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // Read mux; error responses and TOGGLE always return zero.
  always_comb begin
    rd_word = '0;
    if (rd_resp == RESP_OKAY) begin
      unique case (rd_sel)
        REG_OUT: rd_word[NUM_GPIO-1:0] = out_q;
        REG_OE:  rd_word[NUM_GPIO-1:0] = oe_q;
        REG_IN:  rd_word[NUM_GPIO-1:0] = sync2_q;
        default: rd_word = '0;
      endcase
    end
  end

  // Read FSM: register data on the AR handshake and hold it until r_ready_i.
  always_comb begin
    r_state_d  = r_state_q;
    r_data_d   = r_data_q;
    r_resp_d   = r_resp_q;
    ar_ready_o = 1'b0;

    unique case (r_state_q)
      R_IDLE: begin
        ar_ready_o = !reset_i;
        if (ar_valid_i && ar_ready_o) begin
          r_data_d  = rd_word;
          r_resp_d  = rd_resp;
          r_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (r_ready_i) begin
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign r_valid_o = (r_state_q == R_RESP);
  assign r_data_o  = r_data_q;
  assign r_resp_o  = r_resp_q;

  // Read channel state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state_q <= R_IDLE;
      r_data_q  <= '0;
      r_resp_q  <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
    end
  end

endmodule

// File: tb/tb_gpio_axil_responder.sv
// Testbench for gpio_axil_responder: directed steps followed by randomized
// reads and writes checked against a register-level model.

module tb_gpio_axil_responder;

  localparam int          NG   = 32;
  localparam logic [63:0] BASE = 64'h0010_0000;
  localparam logic [63:0] LEN  = 64'h0001_0000;
  localparam logic [63:0] MASK = (64'd1 << NG) - 64'd1;

  logic          clk = 1'b0;
  logic          reset;
  logic [63:0]   aw_addr;
  logic          aw_valid;
  logic          aw_ready;
  logic [63:0]   w_data;
  logic [7:0]    w_strb;
  logic          w_valid;
  logic          w_ready;
  logic [1:0]    b_resp;
  logic          b_valid;
  logic          b_ready;
  logic [63:0]   ar_addr;
  logic          ar_valid;
  logic          ar_ready;
  logic [63:0]   r_data;
  logic [1:0]    r_resp;
  logic          r_valid;
  logic          r_ready;
  logic [NG-1:0] gpio_o;
  logic [NG-1:0] gpio_oe;
  logic [NG-1:0] gpio_i;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  logic [63:0] out_m, oe_m, in_m;

  always #5 clk = ~clk;

  gpio_axil_responder #(
    .ADDR_WIDTH(64), .DATA_WIDTH(64), .NUM_GPIO(NG),
    .BASE_ADDR(BASE), .WINDOW_LEN(LEN)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .aw_addr_i(aw_addr), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
    .w_data_i(w_data), .w_strb_i(w_strb), .w_valid_i(w_valid), .w_ready_o(w_ready),
    .b_resp_o(b_resp), .b_valid_o(b_valid), .b_ready_i(b_ready),
    .ar_addr_i(ar_addr), .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
    .r_data_o(r_data), .r_resp_o(r_resp), .r_valid_o(r_valid), .r_ready_i(r_ready),
    .gpio_o(gpio_o), .gpio_oe_o(gpio_oe), .gpio_i(gpio_i)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected $finish before 500us");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [1:0] m_resp(input logic [63:0] a);
    if (a < BASE || a >= BASE + LEN) return 2'b11;
    if (a - BASE < 64'h20)           return 2'b00;
    return 2'b10;
  endfunction

  function automatic logic [63:0] m_read(input logic [63:0] a);
    if (m_resp(a) != 2'b00) return 64'd0;
    case ((a - BASE) / 8)
      0:       return out_m & MASK;
      1:       return oe_m & MASK;
      2:       return in_m & MASK;
      default: return 64'd0;
    endcase
  endfunction

  task automatic m_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] strb);
    logic [63:0] bm;
    bm = 64'd0;
    for (int k = 0; k < 8; k++)
      if (strb[k]) bm = bm | (64'hFF << (8 * k));
    if (m_resp(a) == 2'b00) begin
      case ((a - BASE) / 8)
        0:       out_m = (out_m & ~bm) | (d & bm);
        1:       oe_m  = (oe_m & ~bm) | (d & bm);
        3:       out_m = out_m ^ (d & bm);
        default: ;
      endcase
    end
    out_m = out_m & MASK;
    oe_m  = oe_m & MASK;
  endtask

  function automatic logic [63:0] rand_addr();
    int unsigned s;
    logic [63:0] lo;
    s  = $urandom_range(0, 9);
    lo = 64'($urandom_range(0, 7));
    if (s < 6) return BASE + 64'($urandom_range(0, 3)) * 8 + lo;
    if (s < 8) return BASE + 64'($urandom_range(4, 'h1FFF)) * 8 + lo;
    if (s == 8) return BASE - 64'($urandom_range(1, 16));
    return BASE + LEN + 64'($urandom_range(0, 64));
  endfunction

  // ---------------- bus tasks ----------------
  task automatic do_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    logic [1:0] er;
    logic aw_done, w_done, aw_hs, w_hs;
    int cyc;
    er = m_resp(addr);
    aw_done = 1'b0; w_done = 1'b0; cyc = 0;
    aw_addr = addr; w_data = data; w_strb = strb;
    while (!(aw_done && w_done) && cyc < 40) begin
      aw_valid = !aw_done && (cyc >= aw_dly);
      w_valid  = !w_done && (cyc >= w_dly);
      aw_hs = aw_valid && aw_ready;
      w_hs  = w_valid && w_ready;
      @(posedge clk); #1;
      aw_done = aw_done | aw_hs;
      w_done  = w_done | w_hs;
      cyc++;
    end
    aw_valid = 1'b0; w_valid = 1'b0;
    chk("wr_handshake", {62'd0, aw_done, w_done}, 64'd3);
    chk("b_not_early", b_valid, 0);
    m_write(addr, data, strb);
    @(posedge clk); #1;
    chk("b_valid", b_valid, 1);
    chk("b_resp", b_resp, er);
    chk("gpio_o", gpio_o, out_m[NG-1:0]);
    chk("gpio_oe", gpio_oe, oe_m[NG-1:0]);
    repeat (b_dly) begin
      @(posedge clk); #1;
      chk("b_hold", {b_valid, b_resp}, {1'b1, er});
      chk("wr_ready_in_resp", {aw_ready, w_ready}, 0);
    end
    b_ready = 1'b1;
    @(posedge clk); #1;
    b_ready = 1'b0;
    chk("b_done", b_valid, 0);
    chk("wr_ready_after_b", {aw_ready, w_ready}, 2'b11);
  endtask

  task automatic do_read(input logic [63:0] addr, input int ar_dly, input int r_dly);
    logic [63:0] ed;
    logic [1:0] er;
    logic done, hs;
    int cyc;
    ed = m_read(addr);
    er = m_resp(addr);
    done = 1'b0; cyc = 0;
    ar_addr = addr;
    while (!done && cyc < 40) begin
      ar_valid = (cyc >= ar_dly);
      hs = ar_valid && ar_ready;
      @(posedge clk); #1;
      done = hs;
      cyc++;
    end
    ar_valid = 1'b0;
    chk("ar_handshake", done, 1);
    chk("r_valid", r_valid, 1);
    chk("r_data", r_data, ed);
    chk("r_resp", r_resp, er);
    repeat (r_dly) begin
      @(posedge clk); #1;
      chk("r_hold", {r_valid, r_resp, r_data}, {1'b1, er, ed});
    end
    r_ready = 1'b1;
    @(posedge clk); #1;
    r_ready = 1'b0;
    chk("r_done", r_valid, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] d, exp_r;
    reset = 1'b1;
    aw_addr = '0; aw_valid = 1'b0; w_data = '0; w_strb = '0; w_valid = 1'b0;
    b_ready = 1'b0; ar_addr = '0; ar_valid = 1'b0; r_ready = 1'b0; gpio_i = '0;
    out_m = '0; oe_m = '0; in_m = '0;

    // reset
    #1;
    chk("ready_in_reset", {aw_ready, w_ready, ar_ready}, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gpio_o", gpio_o, 0);
    chk("rst_gpio_oe", gpio_oe, 0);
    chk("rst_valids", {b_valid, r_valid}, 0);
    chk("rst_resps", {b_resp, r_resp}, 0);
    chk("rst_r_data", r_data, 0);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", {aw_ready, w_ready, ar_ready}, 3'b111);

    // OUT write/readback
    do_write(BASE + 64'h00, 64'hA5A5_5A5A, 8'hFF, 0, 0, 0);
    chk("out_a5", gpio_o, 32'hA5A5_5A5A);
    do_read(BASE + 64'h00, 0, 0);

    // W leads AW by two cycles; strobes select bytes 2 and 3
    do_write(BASE + 64'h08, 64'hFFFF_0000, 8'h0C, 2, 0, 1);
    chk("oe_strb", gpio_oe, 32'hFFFF_0000);
    repeat (3) begin
      @(posedge clk); #1;
      chk("single_b", b_valid, 0);
    end

    // TOGGLE
    do_write(BASE + 64'h00, 64'h0000_00F0, 8'hFF, 0, 1, 0);
    do_write(BASE + 64'h18, 64'h0000_0FF0, 8'hFF, 1, 1, 0);
    chk("toggle", gpio_o, 32'h0000_0F00);
    do_read(BASE + 64'h18, 0, 0);

    // synchronizer latency: AR one cycle after change sees old value, three cycles after sees new
    gpio_i = 32'h1234_5678;
    @(posedge clk); #1;
    do_read(BASE + 64'h10, 0, 0);
    in_m = 64'h1234_5678;
    do_read(BASE + 64'h10, 0, 0);

    // error responses
    do_read(BASE + 64'h20, 0, 0);
    do_write(64'h0030_0000, 64'hFFFF_FFFF, 8'hFF, 0, 0, 0);
    chk("decerr_no_change", gpio_o, 32'h0000_0F00);
    do_read(64'h0030_0000, 1, 1);
    do_read(BASE + LEN - 64'd1, 0, 0);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      int unsigned op;
      op = $urandom_range(0, 5);
      if (op <= 2) begin
        do_write(rand_addr(), {$urandom, $urandom}, 8'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      end else if (op <= 4) begin
        do_read(rand_addr(), $urandom_range(0, 2), $urandom_range(0, 2));
      end else begin
        gpio_i = NG'($urandom);
        repeat (2) @(posedge clk);
        #1;
        in_m = 64'(gpio_i);
      end
    end

    // concurrent read and write with both responses stalled, then reset
    d = {$urandom, $urandom};
    exp_r = m_read(BASE + 64'h08);
    aw_addr = BASE; w_data = d; w_strb = 8'hFF; ar_addr = BASE + 64'h08;
    aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1;
    @(posedge clk); #1;
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    chk("cc_r_valid", r_valid, 1);
    chk("cc_r_data", r_data, exp_r);
    m_write(BASE, d, 8'hFF);
    @(posedge clk); #1;
    chk("cc_b_valid", b_valid, 1);
    chk("cc_gpio_o", gpio_o, out_m[NG-1:0]);
    repeat (5) begin
      @(posedge clk); #1;
      chk("cc_b_hold", {b_valid, b_resp}, 3'b100);
      chk("cc_r_hold", {r_valid, r_resp, r_data}, {1'b1, 2'b00, exp_r});
      chk("cc_wr_ready", {aw_ready, w_ready}, 0);
    end
    reset = 1'b1;
    #1;
    chk("cc_ready_in_reset", {aw_ready, w_ready, ar_ready}, 0);
    @(posedge clk); #1;
    chk("cc_rst_gpio", {gpio_o, gpio_oe}, 0);
    chk("cc_rst_valid", {b_valid, r_valid}, 0);
    chk("cc_rst_resp", {b_resp, r_resp}, 0);
    chk("cc_rst_r_data", r_data, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
